// File: rtl/interp_if.sv
// Sample-stream bundle between the baseband source, the linear upsampler and the mixer.
interface interp_if #(
  parameter int DATA_W = 15
) ();
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     underrun_clr;
  logic signed [DATA_W-1:0] interp_o;
  logic                     out_valid;
  logic                     underrun;

  modport master (
    output in_data, in_valid, underrun_clr,
    input  in_ready, interp_o, out_valid, underrun
  );

  modport slave (
    input  in_data, in_valid, underrun_clr,
    output in_ready, interp_o, out_valid, underrun
  );
endinterface

// File: rtl/interp_linear_up.sv
// Linear-interpolating upsampler (L = 2^LOG2_L) feeding the mixer's interp_i.
// Define INTERP_ROUND_EN to round half toward +inf instead of flooring.
module interp_linear_up #(
  parameter int DATA_W = 15,
  parameter int LOG2_L = 2
) (
  input  logic    clk,
  input  logic    rst,
  interp_if.slave bus
);
  localparam int ACC_W  = DATA_W + LOG2_L + 1;
  localparam int DIFF_W = DATA_W + 1;
  localparam logic [LOG2_L-1:0] PH_LAST = '1;

  typedef enum logic {PRIME, RUN} state_t;

  state_t                   state, state_d;
  logic signed [DATA_W-1:0] cur, cur_d, nxt, nxt_d;
  logic                     nxt_full, nxt_full_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic signed [DIFF_W-1:0] diff, diff_d;
  logic [LOG2_L-1:0]        phase, phase_d;
  logic signed [DATA_W-1:0] interp_nx, interp_d;
  logic                     out_valid_d, underrun_d, xfer, reload;

  // acc carries LOG2_L fractional bits; the output is its integer part
`ifdef INTERP_ROUND_EN
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (LOG2_L - 1);
  assign interp_nx = DATA_W'((acc + HALF) >>> LOG2_L);
`else
  assign interp_nx = DATA_W'(acc >>> LOG2_L);
`endif

  assign reload = (state == RUN) && (phase == PH_LAST);

  always_comb begin
    state_d     = state;
    cur_d       = cur;
    nxt_d       = nxt;
    nxt_full_d  = nxt_full;
    acc_d       = acc;
    diff_d      = diff;
    phase_d     = phase;
    interp_d    = bus.interp_o;
    out_valid_d = bus.out_valid;
    underrun_d  = bus.underrun & ~bus.underrun_clr;
    xfer        = bus.in_valid & bus.in_ready;
    case (state)
      PRIME: begin
        if (xfer) begin
          cur_d   = bus.in_data;
          acc_d   = ACC_W'(bus.in_data) <<< LOG2_L;
          diff_d  = '0;
          phase_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        interp_d    = interp_nx;
        out_valid_d = 1'b1;
        phase_d     = phase + LOG2_L'(1);
        if (xfer) nxt_d = bus.in_data;
        // a reload frees the buffer; a same-cycle transfer refills it
        nxt_full_d  = (nxt_full && !reload) || xfer;
        if (reload) begin
          acc_d = ACC_W'(cur) <<< LOG2_L;
          if (nxt_full) begin
            diff_d = DIFF_W'(nxt) - DIFF_W'(cur);
            cur_d  = nxt;
          end else begin
            diff_d     = '0;
            underrun_d = 1'b1;
          end
        end else begin
          acc_d = acc + ACC_W'(diff);
        end
      end
      default: state_d = PRIME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PRIME;
      cur           <= '0;
      nxt           <= '0;
      nxt_full      <= 1'b0;
      acc           <= '0;
      diff          <= '0;
      phase         <= '0;
      bus.interp_o  <= '0;
      bus.out_valid <= 1'b0;
      bus.underrun  <= 1'b0;
      bus.in_ready  <= 1'b1;
    end else begin
      state         <= state_d;
      cur           <= cur_d;
      nxt           <= nxt_d;
      nxt_full      <= nxt_full_d;
      acc           <= acc_d;
      diff          <= diff_d;
      phase         <= phase_d;
      bus.interp_o  <= interp_d;
      bus.out_valid <= out_valid_d;
      bus.underrun  <= underrun_d;
      bus.in_ready  <= !nxt_full_d;
    end
  end
endmodule
